// File: rtl/mult_pkg.sv
// Shared types and constants for the approximate-multiplier operand path.
// Holds the default operand width, the feeder state enum and the operand-pair struct.
// No ports; imported by the feeder RTL and its bench.
package mult_pkg;

  // Default operand width; must match the multiplier input width.
  localparam int unsigned MULT_WIDTH = 16;

  // Feeder control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } feeder_state_e;

  // One operand pair as carried through the FIFO: a goes to in1, b goes to in2.
  typedef struct packed {
    logic [MULT_WIDTH-1:0] a;
    logic [MULT_WIDTH-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/mult_operand_feeder_if.sv
// Bundle of the feeder's stream, multiplier and status signals.
// master: feeder side (drives in_ready, mult_in1/2, mult_start, busy, count, zero_hit).
// slave: environment side (drives in_valid, in_a, in_b, mult_done).
interface mult_operand_feeder_if #(
  parameter int unsigned WIDTH = mult_pkg::MULT_WIDTH,
  parameter int unsigned DEPTH = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic [WIDTH-1:0]         mult_in1;
  logic [WIDTH-1:0]         mult_in2;
  logic                     mult_start;
  logic                     mult_done;
  logic                     busy;
  logic [$clog2(DEPTH):0]   count;
  logic                     zero_hit;

  modport master (
    input  in_valid, in_a, in_b, mult_done,
    output in_ready, mult_in1, mult_in2, mult_start, busy, count, zero_hit
  );

  modport slave (
    output in_valid, in_a, in_b, mult_done,
    input  in_ready, mult_in1, mult_in2, mult_start, busy, count, zero_hit
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; power-of-two DEPTH, pointers wrap naturally.
// Latency: a pushed word is visible at rdata_o the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty/count are registered-state only.
// Ports: clk, rst (async active-high), push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, count_o.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mult_operand_feeder.sv
// Operand feeder: queues {a,b} pairs and hands one at a time to the multiplier with a start pulse.
// Latency: push at edge t into empty idle feeder -> pop at t+1, mult_start high t+1..t+2.
// Backpressure: in_ready = !full (from count only); next pair issues only after mult_done in WAIT.
// Ports: clk, rst (async active-high); bus (mult_operand_feeder_if.master) carries
//   in_valid/in_ready/in_a/in_b, mult_in1/mult_in2/mult_start/mult_done, busy, count, zero_hit.
// Build option: define MOF_ZERO_BYPASS_EN to skip pairs with a zero operand and pulse zero_hit.
module mult_operand_feeder
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  mult_operand_feeder_if.master bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;

  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       in1_q, in1_d;
  logic [WIDTH-1:0]       in2_q, in2_d;

  logic                   fifo_push, fifo_pop;
  logic                   fifo_full, fifo_empty;
  logic [2*WIDTH-1:0]     fifo_wdata, fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [WIDTH-1:0]       head_a, head_b;

  assign fifo_push  = bus.in_valid && !fifo_full;
  assign fifo_wdata = {bus.in_a, bus.in_b};
  // Only IDLE consumes; empty is registered, so a same-cycle push into an empty FIFO waits a cycle.
  assign fifo_pop   = (state_q == S_IDLE) && !fifo_empty;
  assign head_a     = fifo_rdata[2*WIDTH-1:WIDTH];
  assign head_b     = fifo_rdata[WIDTH-1:0];

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (2*WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef MOF_ZERO_BYPASS_EN
  logic zero_hit_q, zero_hit_d;
`endif

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
`ifdef MOF_ZERO_BYPASS_EN
    zero_hit_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
`ifdef MOF_ZERO_BYPASS_EN
          // A zero operand makes the product trivially zero: drop the pair,
          // keep the held operands, and stay in IDLE so the next pair can pop.
          if ((head_a == '0) || (head_b == '0)) begin
            zero_hit_d = 1'b1;
          end else begin
            in1_d   = head_a;
            in2_d   = head_b;
            state_d = S_ISSUE;
          end
`else
          in1_d   = head_a;
          in2_d   = head_b;
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.mult_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
    end
  end

`ifdef MOF_ZERO_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_hit_q <= 1'b0;
    else     zero_hit_q <= zero_hit_d;
  end
  assign bus.zero_hit = zero_hit_q;
`else
  assign bus.zero_hit = 1'b0;
`endif

  assign bus.in_ready   = !fifo_full;
  assign bus.count      = fifo_count;
  assign bus.mult_in1   = in1_q;
  assign bus.mult_in2   = in2_q;
  assign bus.mult_start = (state_q == S_ISSUE);
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Bench for mult_operand_feeder: directed pushes/done pulses, a queue-level
// reference model checked every cycle on the falling edge, plus literal checks.
module tb_mult_operand_feeder;
  import mult_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
`ifdef MOF_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_operand_feeder_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bif ();

  mult_operand_feeder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_zero  = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of accepted pairs plus the issue phase
  // (0 idle, 1 start cycle, 2 waiting for done).
  op_pair_t    m_q[$];
  int          m_phase = 0;
  logic [15:0] m_in1 = '0;
  logic [15:0] m_in2 = '0;
  bit          m_zero = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_phase = 0;
      m_in1   = '0;
      m_in2   = '0;
      m_zero  = 1'b0;
    end else begin
      bit       accept;
      op_pair_t p;
      accept = bif.in_valid && (m_q.size() < DEPTH);
      m_zero = 1'b0;
      case (m_phase)
        0: if (m_q.size() > 0) begin
          p = m_q.pop_front();
          if (BYPASS && (p.a == 0 || p.b == 0)) m_zero = 1'b1;
          else begin
            m_in1   = p.a;
            m_in2   = p.b;
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        default: if (bif.mult_done) m_phase = 0;
      endcase
      if (accept) m_q.push_back('{a: bif.in_a, b: bif.in_b});
    end
  end

  always @(negedge clk) begin
    if (!rst && run_chk) begin
      chk("count",    32'(bif.count),      32'(m_q.size()));
      chk("in_ready", 32'(bif.in_ready),   32'(m_q.size() < DEPTH));
      chk("start",    32'(bif.mult_start), 32'(m_phase == 1));
      chk("busy",     32'(bif.busy),       32'(m_phase != 0));
      chk("in1",      32'(bif.mult_in1),   32'(m_in1));
      chk("in2",      32'(bif.mult_in2),   32'(m_in2));
      chk("zero_hit", 32'(bif.zero_hit),   32'(m_zero));
      if (bif.mult_start) n_start++;
      if (bif.zero_hit)   n_zero++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stand-in multiplier: raises done two cycles after each observed start.
  task automatic run_mult(input int cycles);
    int age = -1;
    for (int i = 0; i < cycles; i++) begin
      if (bif.mult_start) age = 0;
      else if (age >= 0) age++;
      if (age == 2) begin
        bif.mult_done = 1'b1;
        age = -1;
      end else begin
        bif.mult_done = 1'b0;
      end
      tick();
    end
    bif.mult_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, z0;
    bif.in_valid  = 1'b0;
    bif.in_a      = '0;
    bif.in_b      = '0;
    bif.mult_done = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    run_chk = 1'b1;

    // Reset state
    chk("rst_count",    32'(bif.count), 0);
    chk("rst_in_ready", 32'(bif.in_ready), 1);
    chk("rst_start",    32'(bif.mult_start), 0);
    chk("rst_busy",     32'(bif.busy), 0);
    chk("rst_in1",      32'(bif.mult_in1), 0);
    chk("rst_in2",      32'(bif.mult_in2), 0);
    chk("rst_zero",     32'(bif.zero_hit), 0);

    // Single pair: push at edge t, start during t+1..t+2
    s0 = n_start;
    bif.in_valid = 1'b1; bif.in_a = 16'h00F3; bif.in_b = 16'h0A01;
    tick();
    bif.in_valid = 1'b0;
    chk("t_count1", 32'(bif.count), 1);
    chk("t_start0", 32'(bif.mult_start), 0);
    tick();
    chk("t1_start", 32'(bif.mult_start), 1);
    chk("t1_in1",   32'(bif.mult_in1), 32'h00F3);
    chk("t1_in2",   32'(bif.mult_in2), 32'h0A01);
    chk("t1_count", 32'(bif.count), 0);
    tick();
    chk("t2_start", 32'(bif.mult_start), 0);
    chk("t2_busy",  32'(bif.busy), 1);
    repeat (3) tick();
    chk("wait_busy", 32'(bif.busy), 1);
    bif.mult_done = 1'b1;
    tick();
    bif.mult_done = 1'b0;
    chk("done_idle", 32'(bif.busy), 0);
    chk("one_start", 32'(n_start - s0), 1);

    // done in IDLE with empty FIFO is ignored
    s0 = n_start;
    bif.mult_done = 1'b1;
    repeat (3) tick();
    bif.mult_done = 1'b0;
    chk("idle_done_busy",  32'(bif.busy), 0);
    chk("idle_done_start", 32'(n_start - s0), 0);

    // Fill: 5 pairs back to back with done low -> 1 issued, 4 queued
    bif.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bif.in_a = 16'h0100 + 16'(k);
      bif.in_b = 16'h0200 + 16'(k);
      tick();
    end
    chk("full_count", 32'(bif.count), 4);
    chk("full_rdy",   32'(bif.in_ready), 0);
    chk("full_busy",  32'(bif.busy), 1);
    bif.in_a = 16'h0105; bif.in_b = 16'h0205;  // sixth pair held on the stream
    repeat (2) tick();
    chk("refused_count", 32'(bif.count), 4);
    bif.mult_done = 1'b1;
    tick();
    bif.mult_done = 1'b0;
    chk("A_busy",  32'(bif.busy), 0);
    chk("A_count", 32'(bif.count), 4);
    tick();
    // Pop happened but push was refused (no pass-through on full)
    chk("B_count", 32'(bif.count), 3);
    chk("B_start", 32'(bif.mult_start), 1);
    chk("B_in1",   32'(bif.mult_in1), 32'h0101);
    // done during ISSUE is ignored
    bif.mult_done = 1'b1;
    tick();
    bif.in_valid  = 1'b0;
    bif.mult_done = 1'b0;
    chk("C_count", 32'(bif.count), 4);
    chk("C_busy",  32'(bif.busy), 1);
    tick();
    chk("C2_busy",  32'(bif.busy), 1);
    chk("C2_start", 32'(bif.mult_start), 0);
    bif.mult_done = 1'b1;
    tick();
    bif.mult_done = 1'b0;
    chk("D_idle",  32'(bif.busy), 0);
    chk("D_start", 32'(bif.mult_start), 0);
    tick();
    chk("D2_start", 32'(bif.mult_start), 1);
    chk("D2_in1",   32'(bif.mult_in1), 32'h0102);
    run_mult(40);
    chk("drain_count", 32'(bif.count), 0);
    chk("drain_in1",   32'(bif.mult_in1), 32'h0105);
    chk("drain_in2",   32'(bif.mult_in2), 32'h0205);

    // Reset in WAIT with 3 queued
    bif.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bif.in_a = 16'h0300 + 16'(k);
      bif.in_b = 16'h0400 + 16'(k);
      tick();
    end
    bif.in_valid = 1'b0;
    chk("pre_rst_count", 32'(bif.count), 3);
    chk("pre_rst_busy",  32'(bif.busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(bif.count), 0);
    chk("mid_rst_start", 32'(bif.mult_start), 0);
    chk("mid_rst_busy",  32'(bif.busy), 0);
    chk("mid_rst_in1",   32'(bif.mult_in1), 0);
    chk("mid_rst_in2",   32'(bif.mult_in2), 0);
    chk("mid_rst_rdy",   32'(bif.in_ready), 1);
    tick();
    rst = 1'b0;
    s0 = n_start;
    repeat (10) tick();
    chk("post_rst_starts", 32'(n_start - s0), 0);
    chk("post_rst_count",  32'(bif.count), 0);

    // Zero operand pair followed by a normal pair
    s0 = n_start;
    z0 = n_zero;
    bif.in_valid = 1'b1; bif.in_a = 16'h0000; bif.in_b = 16'h1234;
    tick();
    bif.in_a = 16'h0003; bif.in_b = 16'h0005;
    tick();
    bif.in_valid = 1'b0;
    run_mult(30);
    chk("zero_starts", 32'(n_start - s0), BYPASS ? 1 : 2);
    chk("zero_hits",   32'(n_zero - z0),  BYPASS ? 1 : 0);
    chk("zero_in1",    32'(bif.mult_in1), 32'h0003);
    chk("zero_in2",    32'(bif.mult_in2), 32'h0005);
    chk("zero_idle",   32'(bif.busy), 0);

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
